// File: rtl/mem_dump_unit.sv
// -----------------------------------------------------------------------------
// mem_dump_unit
// Sweeps the data memory one aligned word at a time and streams every word,
// MSB byte first, over a valid/ready byte stream towards the UART transmitter.
// A one-byte XOR checksum of all streamed bytes follows the last word.
//
// Ports:
//   i_clk, i_rst_n        clock (rising edge), synchronous active-low reset
//   i_start, i_abort      start a dump (IDLE only) / abandon a dump in progress
//   o_busy, o_done        not-IDLE flag / one-cycle pulse after checksum accept
//   o_mem_r_*             memory read port (word addressing, unsigned)
//   i_mem_r_data          read data, valid one clock after addr/en
//   o_tx_data/valid       byte stream out, i_tx_ready stream back-pressure
// -----------------------------------------------------------------------------
module mem_dump_unit #(
    parameter int unsigned NB_DATA_BUS = 32,
    parameter int unsigned N_ADDRESS   = 64,
    parameter int unsigned NB_ADDRESS  = $clog2(N_ADDRESS),
    parameter int unsigned NB_BYTE     = 8
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_start,
    input  logic                    i_abort,
    output logic                    o_busy,
    output logic                    o_done,
    output logic [NB_ADDRESS-1:0]   o_mem_r_addr,
    output logic                    o_mem_r_en,
    output logic [1:0]              o_mem_r_addressing,
    output logic                    o_mem_r_signing,
    input  logic [NB_DATA_BUS-1:0]  i_mem_r_data,
    output logic [NB_BYTE-1:0]      o_tx_data,
    output logic                    o_tx_valid,
    input  logic                    i_tx_ready
);

    localparam int unsigned NB_IDX   = NB_ADDRESS - 2;
    localparam int unsigned N_WORDS  = N_ADDRESS / 4;
    localparam int unsigned NB_CNT   = 2;
    localparam logic [NB_IDX-1:0] LAST_IDX = NB_IDX'(N_WORDS - 1);
    localparam logic [NB_CNT-1:0] LAST_BYTE = NB_CNT'(3);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_READ    = 3'd1;
    localparam logic [2:0] ST_CAPTURE = 3'd2;
    localparam logic [2:0] ST_SEND    = 3'd3;
    localparam logic [2:0] ST_CHKSUM  = 3'd4;
    localparam logic [2:0] ST_DONE    = 3'd5;

    // Sequencer state and datapath registers
    logic [2:0]             r_state;
    logic [NB_IDX-1:0]      r_word_idx;
    logic [NB_CNT-1:0]      r_byte_cnt;
    logic [NB_DATA_BUS-1:0] r_shift;
    logic [NB_BYTE-1:0]     r_chk;

    // Registered outputs
    logic                   r_busy;
    logic                   r_done;
    logic                   r_mem_en;
    logic [NB_ADDRESS-1:0]  r_mem_addr;
    logic                   r_tx_valid;
    logic [NB_BYTE-1:0]     r_tx_data;

    // Next-state values
    logic [2:0]             w_state_nxt;
    logic [NB_IDX-1:0]      w_word_idx_nxt;
    logic [NB_CNT-1:0]      w_byte_cnt_nxt;
    logic [NB_DATA_BUS-1:0] w_shift_nxt;
    logic [NB_BYTE-1:0]     w_chk_nxt;
    logic                   w_xfer;
    logic [NB_BYTE-1:0]     w_cur_byte;

    // Next-output values (outputs are registered from the next state)
    logic                   w_busy_nxt;
    logic                   w_done_nxt;
    logic                   w_mem_en_nxt;
    logic [NB_ADDRESS-1:0]  w_mem_addr_nxt;
    logic                   w_tx_valid_nxt;
    logic [NB_BYTE-1:0]     w_tx_data_nxt;

    assign w_xfer     = r_tx_valid & i_tx_ready;
    assign w_cur_byte = r_shift[NB_DATA_BUS-1 -: NB_BYTE];

    // Next-state logic
    always_comb begin
        w_state_nxt    = r_state;
        w_word_idx_nxt = r_word_idx;
        w_byte_cnt_nxt = r_byte_cnt;
        w_shift_nxt    = r_shift;
        w_chk_nxt      = r_chk;

        case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    w_state_nxt    = ST_READ;
                    w_word_idx_nxt = '0;
                    w_chk_nxt      = '0;
                end
            end
            ST_READ: begin
                w_state_nxt = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                // Read data for the address presented in READ is valid now
                w_shift_nxt    = i_mem_r_data;
                w_byte_cnt_nxt = '0;
                w_state_nxt    = ST_SEND;
            end
            ST_SEND: begin
                if (w_xfer) begin
                    w_chk_nxt      = r_chk ^ w_cur_byte;
                    w_shift_nxt    = r_shift << NB_BYTE;
                    w_byte_cnt_nxt = r_byte_cnt + NB_CNT'(1);
                    if (r_byte_cnt == LAST_BYTE) begin
                        if (r_word_idx == LAST_IDX) begin
                            w_state_nxt = ST_CHKSUM;
                        end else begin
                            w_word_idx_nxt = r_word_idx + NB_IDX'(1);
                            w_state_nxt    = ST_READ;
                        end
                    end
                end
            end
            ST_CHKSUM: begin
                if (w_xfer) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        // Abort overrides everything, including a transfer on this edge
        if (i_abort && (r_state != ST_IDLE)) begin
            w_state_nxt = ST_IDLE;
        end
    end

    // Output decode from the next state so outputs line up with the state
    always_comb begin
        w_busy_nxt     = (w_state_nxt != ST_IDLE);
        w_done_nxt     = (w_state_nxt == ST_DONE);
        w_mem_en_nxt   = (w_state_nxt == ST_READ) || (w_state_nxt == ST_CAPTURE);
        w_mem_addr_nxt = {w_word_idx_nxt, 2'b00};
        w_tx_valid_nxt = (w_state_nxt == ST_SEND) || (w_state_nxt == ST_CHKSUM);
        w_tx_data_nxt  = '0;
        if (w_state_nxt == ST_SEND) begin
            w_tx_data_nxt = w_shift_nxt[NB_DATA_BUS-1 -: NB_BYTE];
        end else if (w_state_nxt == ST_CHKSUM) begin
            w_tx_data_nxt = w_chk_nxt;
        end
    end

    // State, datapath and output registers
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state    <= ST_IDLE;
            r_word_idx <= '0;
            r_byte_cnt <= '0;
            r_shift    <= '0;
            r_chk      <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_mem_en   <= 1'b0;
            r_mem_addr <= '0;
            r_tx_valid <= 1'b0;
            r_tx_data  <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_word_idx <= w_word_idx_nxt;
            r_byte_cnt <= w_byte_cnt_nxt;
            r_shift    <= w_shift_nxt;
            r_chk      <= w_chk_nxt;
            r_busy     <= w_busy_nxt;
            r_done     <= w_done_nxt;
            r_mem_en   <= w_mem_en_nxt;
            r_mem_addr <= w_mem_addr_nxt;
            r_tx_valid <= w_tx_valid_nxt;
            r_tx_data  <= w_tx_data_nxt;
        end
    end

    assign o_busy             = r_busy;
    assign o_done             = r_done;
    assign o_mem_r_en         = r_mem_en;
    assign o_mem_r_addr       = r_mem_addr;
    assign o_mem_r_addressing = 2'b11;
    assign o_mem_r_signing    = 1'b0;
    assign o_tx_valid         = r_tx_valid;
    assign o_tx_data          = r_tx_data;

endmodule

// File: tb/tb_mem_dump_unit.sv
// -----------------------------------------------------------------------------
// tb_mem_dump_unit
// Drives dumps of a small memory model and compares the byte stream, address
// sequence, done timing and handshake behaviour against a reference built
// directly from the memory contents.
// -----------------------------------------------------------------------------
module tb_mem_dump_unit;

    localparam int NW        = 16;
    localparam int NBYTES    = NW * 4 + 1;
    localparam int DONE_CYC  = 6 * NW + 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        abort_i;
    logic        busy;
    logic        done;
    logic [5:0]  mem_addr;
    logic        mem_en;
    logic [1:0]  mem_addressing;
    logic        mem_signing;
    logic [31:0] mem_rdata;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;

    always #5 clk = ~clk;

    mem_dump_unit dut (
        .i_clk              (clk),
        .i_rst_n            (rst_n),
        .i_start            (start),
        .i_abort            (abort_i),
        .o_busy             (busy),
        .o_done             (done),
        .o_mem_r_addr       (mem_addr),
        .o_mem_r_en         (mem_en),
        .o_mem_r_addressing (mem_addressing),
        .o_mem_r_signing    (mem_signing),
        .i_mem_r_data       (mem_rdata),
        .o_tx_data          (tx_data),
        .o_tx_valid         (tx_valid),
        .i_tx_ready         (tx_ready)
    );

    // Synchronous-read memory: data valid one clock after addr/en
    logic [31:0] mem [NW];
    always @(posedge clk) begin
        if (mem_en) mem_rdata <= mem[mem_addr[5:2]];
    end

    int checks = 0;
    int errors = 0;

    logic [7:0] exp_q [$];
    logic [7:0] got   [$];
    logic [5:0] addrs [$];
    int done_cnt;
    int done_cyc;
    int stab_bad;

    // Dump knobs
    bit ready_rand      = 1'b0;
    int start2_at       = -1;
    int abort_at        = -1;
    int rst_at_word     = -1;
    bit abort_with_start = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // Reference stream: every word MSB byte first, then XOR of all bytes
    task automatic build_exp();
        logic [7:0] x;
        logic [7:0] b;
        logic [31:0] w;
        x = 8'h00;
        exp_q.delete();
        for (int i = 0; i < NW; i++) begin
            w = mem[i];
            for (int k = 3; k >= 0; k--) begin
                b = w[8*k +: 8];
                exp_q.push_back(b);
                x = x ^ b;
            end
        end
        exp_q.push_back(x);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_busy"},  32'(busy),     32'd0);
        chk({tag, "_done"},  32'(done),     32'd0);
        chk({tag, "_en"},    32'(mem_en),   32'd0);
        chk({tag, "_addr"},  32'(mem_addr), 32'd0);
        chk({tag, "_valid"}, 32'(tx_valid), 32'd0);
        chk({tag, "_data"},  32'(tx_data),  32'd0);
    endtask

    // Runs one dump from an IDLE negedge until the DUT returns to IDLE
    task automatic dump();
        bit prev_hold  = 1'b0;
        bit prev_en    = 1'b0;
        bit abort_pend = 1'b0;
        bit rst_pend   = 1'b0;
        bit finished   = 1'b0;
        logic [7:0] prev_data = 8'h00;
        got.delete();
        addrs.delete();
        done_cnt = 0;
        done_cyc = -1;
        stab_bad = 0;
        start    = 1'b1;
        abort_i  = abort_with_start;
        tx_ready = 1'b1;
        for (int c = 1; c <= 3000; c++) begin
            @(negedge clk);
            start   = 1'b0;
            abort_i = 1'b0;
            if (abort_pend) begin
                chk("abort_busy",  32'(busy),     32'd0);
                chk("abort_valid", 32'(tx_valid), 32'd0);
            end
            if (rst_pend) begin
                chk_reset_outputs("midrst");
                rst_n = 1'b1;
            end
            if (!busy) begin
                finished = 1'b1;
                break;
            end
            if (prev_hold && (tx_valid !== 1'b1 || tx_data !== prev_data)) stab_bad++;
            if (mem_en && !prev_en) addrs.push_back(mem_addr);
            if (done) begin
                done_cnt++;
                done_cyc = c;
            end
            tx_ready = ready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
            if (rst_at_word >= 0 && mem_en && prev_en && addrs.size() == rst_at_word + 1) begin
                rst_n    = 1'b0;
                rst_pend = 1'b1;
            end
            if (abort_at >= 0 && tx_valid && got.size() == abort_at) begin
                abort_i    = 1'b1;
                tx_ready   = 1'b1;
                abort_pend = 1'b1;
            end else if (tx_valid && tx_ready) begin
                got.push_back(tx_data);
            end
            if (start2_at >= 0 && tx_valid && got.size() == start2_at) start = 1'b1;
            prev_en   = mem_en;
            prev_hold = tx_valid && !tx_ready;
            prev_data = tx_data;
        end
        if (!finished) chk("dump_timeout", 32'd1, 32'd0);
    endtask

    task automatic verify(input string tag, input bit check_cyc);
        int nmis;
        chk({tag, "_len"}, 32'(got.size()), 32'(NBYTES));
        nmis = 0;
        for (int i = 0; i < NBYTES; i++) begin
            if (i >= got.size() || got[i] !== exp_q[i]) nmis++;
        end
        chk({tag, "_bytes_bad"}, 32'(nmis), 32'd0);
        if (got.size() > 0) chk({tag, "_chksum"}, 32'(got[got.size()-1]), 32'(exp_q[NBYTES-1]));
        chk({tag, "_done_cnt"}, 32'(done_cnt), 32'd1);
        if (check_cyc) chk({tag, "_done_cyc"}, 32'(done_cyc), 32'(DONE_CYC));
        chk({tag, "_addr_cnt"}, 32'(addrs.size()), 32'(NW));
        nmis = 0;
        for (int i = 0; i < NW; i++) begin
            if (i >= addrs.size() || 32'(addrs[i]) != 32'(i * 4)) nmis++;
        end
        chk({tag, "_addr_bad"}, 32'(nmis), 32'd0);
        chk({tag, "_stable_bad"}, 32'(stab_bad), 32'd0);
    endtask

    task automatic fill_random();
        for (int i = 0; i < NW; i++) mem[i] = $urandom;
    endtask

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        abort_i  = 1'b0;
        tx_ready = 1'b0;
        for (int i = 0; i < NW; i++) mem[i] = 32'h0;
        mem[0] = 32'hDEADBEEF;
        mem[1] = 32'h01020304;

        // Reset values and constant memory controls
        repeat (2) @(negedge clk);
        chk_reset_outputs("reset");
        chk("addressing", 32'(mem_addressing), 32'd3);
        chk("signing",    32'(mem_signing),    32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Abort while idle does nothing
        abort_i = 1'b1;
        @(negedge clk);
        abort_i = 1'b0;
        chk("idle_abort_busy", 32'(busy), 32'd0);

        // Full dump with ready held high
        build_exp();
        dump();
        verify("full", 1'b1);
        if (got.size() > 0) chk("full_chksum_const", 32'(got[got.size()-1]), 32'h26);

        // Back-to-back: start in the idle cycle right after done
        dump();
        verify("b2b", 1'b1);

        // Random backpressure
        ready_rand = 1'b1;
        dump();
        verify("bp", 1'b0);
        ready_rand = 1'b0;

        // Second start during word 3 is ignored
        start2_at = 13;
        dump();
        verify("start2", 1'b1);
        start2_at = -1;
        repeat (3) @(negedge clk);
        chk("start2_idle", 32'(busy), 32'd0);

        // Abort on the 2nd byte of word 5, then restart (abort+start together)
        fill_random();
        build_exp();
        abort_at = 21;
        dump();
        chk("abort_bytes", 32'(got.size()), 32'd21);
        chk("abort_done",  32'(done_cnt),   32'd0);
        abort_at = -1;
        abort_with_start = 1'b1;
        dump();
        abort_with_start = 1'b0;
        verify("restart", 1'b1);

        // Reset during CAPTURE of word 2, stays idle, then a clean dump
        rst_at_word = 2;
        dump();
        chk("midrst_done", 32'(done_cnt), 32'd0);
        rst_at_word = -1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("midrst_idle", 32'({busy, tx_valid, mem_en}), 32'd0);
        end
        dump();
        verify("after_rst", 1'b1);

        // Random contents under random backpressure
        fill_random();
        build_exp();
        ready_rand = 1'b1;
        dump();
        verify("rand_bp", 1'b0);
        ready_rand = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
